algofoogle_product_host: RTL

Host-side driver for the nibble-serial 16×16 multiplier tile. It accepts two 16-bit operands on a start strobe and resets the tile. It then streams the eight operand nibbles into the tile, collects the four returned result bytes, and presents the assembled 32-bit product with a done pulse. It sits on the harness/FPGA side of the tile's 8-bit pin interface and runs on the same clock the tile sees.

---
 rtl/algofoogle_product_host.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/algofoogle_product_host.sv
// Host-side driver for the nibble-serial 16x16 multiplier tile.
// Resets the tile, streams eight operand nibbles MS-first, collects four
// result bytes MS-first and presents the 32-bit product with a done pulse.
// Optional self-check: define PRODUCT_HOST_CHECK_EN to build a local
// multiplier and drive a sticky mismatch flag; otherwise mismatch is 0.
module algofoogle_product_host #(
    parameter int unsigned RX_DELAY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  byte_in,
    output logic [3:0]  nibble_out,
    output logic        dut_reset,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        mismatch
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRst  = 3'd1;
    localparam logic [2:0] StLoad = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StRead = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] ops_q, ops_d;
    logic [23:0] sr_q, sr_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        dut_reset_q, dut_reset_d;

    logic        accept;
    logic        final_capture;
    logic [31:0] assembled;

    assign accept        = (state_q == StIdle) && start;
    assign final_capture = (state_q == StRead) && (cnt_q == 3'd3);
    assign assembled     = {sr_q, byte_in};

    // Next-state logic for the transaction sequencer and its datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ops_d    = ops_q;
        sr_d     = sr_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ops_d   = {a, b};
                    state_d = StRst;
                end
            end
            StRst: begin
                cnt_d   = 3'd0;
                state_d = StLoad;
            end
            StLoad: begin
                ops_d = {ops_q[27:0], 4'h0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // One compute cycle plus the return-path pipeline depth
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(RX_DELAY)) begin
                    cnt_d   = 3'd0;
                    state_d = StRead;
                end
            end
            StRead: begin
                sr_d  = {sr_q[15:0], byte_in};
                cnt_d = cnt_q + 3'd1;
                if (final_capture) begin
                    result_d = assembled;
                    done_d   = 1'b1;
                    cnt_d    = 3'd0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
        // Tile is held in reset whenever no transaction is streaming
        dut_reset_d = (state_d == StIdle) || (state_d == StRst);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            ops_q       <= 32'd0;
            sr_q        <= 24'd0;
            result_q    <= 32'd0;
            done_q      <= 1'b0;
            dut_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ops_q       <= ops_d;
            sr_q        <= sr_d;
            result_q    <= result_d;
            done_q      <= done_d;
            dut_reset_q <= dut_reset_d;
        end
    end

    assign nibble_out = (state_q == StLoad) ? ops_q[31:28] : 4'h0;
    assign dut_reset  = dut_reset_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign result     = result_q;

`ifdef PRODUCT_HOST_CHECK_EN
    logic [31:0] opnd_q;
    logic [31:0] local_prod;
    logic        mismatch_q, mismatch_d;

    assign local_prod = 32'(opnd_q[31:16]) * 32'(opnd_q[15:0]);

    // Sticky flag, updated alongside the result load
    always_comb begin
        mismatch_d = mismatch_q;
        if (final_capture) begin
            mismatch_d = mismatch_q | (assembled != local_prod);
        end
    end

    // Operand copy survives the nibble shift so the local product stays valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd_q     <= 32'd0;
            mismatch_q <= 1'b0;
        end else begin
            if (accept) begin
                opnd_q <= {a, b};
            end
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign mismatch      = 1'b0;
`endif

endmodule
